// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: fetches pixel words, shifts one bit plane per row into the
// panel chain (3 clocks per column), then latches on the timer's request.
module hub75_scan_ctrl #(
  parameter int hpixel_p       = 64,
  parameter int vpixel_p       = 64,
  parameter int segments_p     = 2,
  parameter int bpp_p          = 8,
  parameter int latch_cycles_p = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_enable,
  input  logic                                    i_latch_req,
  output logic                                    o_rd_en,
  output logic [$clog2(vpixel_p/segments_p)-1:0]  o_rd_row,
  output logic [$clog2(hpixel_p)-1:0]             o_rd_col,
  input  logic [segments_p*3*bpp_p-1:0]           i_rd_data,
  output logic [segments_p*3-1:0]                 o_rgb,
  output logic                                    o_sclk,
  output logic                                    o_latch,
  output logic                                    o_ready,
  output logic [$clog2(vpixel_p/segments_p)-1:0]  o_disp_row,
  output logic [$clog2(bpp_p)-1:0]                o_disp_bit,
  output logic                                    o_frame_done,
  output logic                                    o_underrun
);

  localparam int ROWS = vpixel_p / segments_p;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(hpixel_p);
  localparam int BW   = $clog2(bpp_p);
  localparam int DW   = segments_p * 3 * bpp_p;
  localparam int NC   = segments_p * 3;
  localparam int LW   = $clog2(latch_cycles_p + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_CLK   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_LATCH = 3'd5;

  logic [2:0]    state;
  logic [RW-1:0] row;
  logic [BW-1:0] plane;
  logic [CW-1:0] col;
  logic [LW-1:0] lat_cnt;

  logic last_col;
  logic last_row;
  logic last_plane;

  assign last_col   = (col   == CW'(hpixel_p - 1));
  assign last_row   = (row   == RW'(ROWS - 1));
  assign last_plane = (plane == BW'(bpp_p - 1));

  // Pick bit 'b' out of every (segment, colour) field of a pixel word.
  function automatic logic [NC-1:0] plane_bits(input logic [DW-1:0] d, input logic [BW-1:0] b);
    logic [NC-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      r[i] = d[i*bpp_p + int'(b)];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      row          <= '0;
      plane        <= '0;
      col          <= '0;
      lat_cnt      <= '0;
      o_rd_en      <= 1'b0;
      o_rd_row     <= '0;
      o_rd_col     <= '0;
      o_rgb        <= '0;
      o_sclk       <= 1'b0;
      o_latch      <= 1'b0;
      o_ready      <= 1'b0;
      o_disp_row   <= '0;
      o_disp_bit   <= '0;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
      if (!i_enable) begin
        // Disable discards any partial plane and restarts the frame from row 0, bit 0.
        state      <= S_IDLE;
        row        <= '0;
        plane      <= '0;
        col        <= '0;
        lat_cnt    <= '0;
        o_rd_en    <= 1'b0;
        o_rd_row   <= '0;
        o_rd_col   <= '0;
        o_rgb      <= '0;
        o_sclk     <= 1'b0;
        o_latch    <= 1'b0;
        o_ready    <= 1'b0;
        o_disp_row <= '0;
        o_disp_bit <= '0;
      end else begin
        if (i_latch_req && state != S_WAIT && state != S_IDLE) begin
          o_underrun <= 1'b1;
        end
        case (state)
          S_IDLE: begin
            col   <= '0;
            state <= S_READ;
          end
          S_READ: begin
            o_rd_en  <= 1'b1;
            o_rd_row <= row;
            o_rd_col <= col;
            o_sclk   <= 1'b0;
            state    <= S_SETUP;
          end
          S_SETUP: begin
            o_rd_en <= 1'b0;
            o_rgb   <= plane_bits(i_rd_data, plane);
            o_sclk  <= 1'b0;
            state   <= S_CLK;
          end
          S_CLK: begin
            o_sclk <= 1'b1;
            if (!last_col) begin
              col   <= col + CW'(1);
              state <= S_READ;
            end else begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            o_sclk <= 1'b0;
            if (i_latch_req) begin
              o_ready      <= 1'b0;
              o_latch      <= 1'b1;
              o_disp_row   <= row;
              o_disp_bit   <= plane;
              o_frame_done <= last_row && last_plane;
              lat_cnt      <= LW'(1);
              state        <= S_LATCH;
            end else begin
              o_ready <= 1'b1;
            end
          end
          S_LATCH: begin
            if (lat_cnt >= LW'(latch_cycles_p)) begin
              o_latch <= 1'b0;
              col     <= '0;
              state   <= S_READ;
              if (last_plane) begin
                plane <= '0;
                row   <= last_row ? '0 : row + RW'(1);
              end else begin
                plane <= plane + BW'(1);
              end
            end else begin
              lat_cnt <= lat_cnt + LW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: cycle table for the first columns, scoreboard for
// shifted plane data, and directed sequences for latch, frame wrap, underrun and disable.
module tb_hub75_scan_ctrl;

  localparam int H    = 64;
  localparam int ROWS = 32;
  localparam int BPP  = 8;
  localparam int NC   = 6;
  localparam int DW   = 48;
  localparam int LC   = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          lr;
  logic          o_rd_en;
  logic [4:0]    o_rd_row;
  logic [5:0]    o_rd_col;
  logic [DW-1:0] i_rd_data = '0;
  logic [NC-1:0] o_rgb;
  logic          o_sclk;
  logic          o_latch;
  logic          o_ready;
  logic [4:0]    o_disp_row;
  logic [2:0]    o_disp_bit;
  logic          o_frame_done;
  logic          o_underrun;

  hub75_scan_ctrl #(
    .hpixel_p(64), .vpixel_p(64), .segments_p(2), .bpp_p(8), .latch_cycles_p(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_latch_req(lr),
    .o_rd_en(o_rd_en), .o_rd_row(o_rd_row), .o_rd_col(o_rd_col), .i_rd_data(i_rd_data),
    .o_rgb(o_rgb), .o_sclk(o_sclk), .o_latch(o_latch), .o_ready(o_ready),
    .o_disp_row(o_disp_row), .o_disp_bit(o_disp_bit),
    .o_frame_done(o_frame_done), .o_underrun(o_underrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] gen(input logic [4:0] r, input logic [5:0] c);
    logic [DW-1:0] d;
    d = '0;
    for (int f = 0; f < NC; f++)
      d[f*8 +: 8] = 8'((int'(r) * 7 + int'(c) * 13 + f * 29 + 11) ^ (int'(c) << 2));
    return d;
  endfunction

  function automatic logic [NC-1:0] plane_of(input logic [DW-1:0] d, input int b);
    logic [NC-1:0] r;
    r = '0;
    for (int f = 0; f < NC; f++) r[f] = d[f*8 + b];
    return r;
  endfunction

  // Frame-buffer model, reference plane position and scoreboard.
  logic [NC-1:0] exp_q[$];
  int m_row = 0, m_bit = 0, m_col = 0;
  int sclk_cnt = 0, rd_cnt = 0, latch_cnt = 0, fd_cnt = 0, und_cnt = 0;
  logic sclk_q = 1'b0, latch_q = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rd_en) begin
        check("rd_row", 32'(o_rd_row), 32'(m_row));
        check("rd_col", 32'(o_rd_col), 32'(m_col));
        i_rd_data = gen(o_rd_row, o_rd_col);
        exp_q.push_back(plane_of(gen(o_rd_row, o_rd_col), m_bit));
        m_col = (m_col == H - 1) ? 0 : m_col + 1;
        rd_cnt++;
      end else begin
        i_rd_data = {16'($urandom), $urandom};
      end
      if (o_sclk && !sclk_q) begin
        if (exp_q.size() == 0) check("sb_nonempty", 32'(exp_q.size()), 32'd1);
        else check("rgb", 32'(o_rgb), 32'(exp_q.pop_front()));
        sclk_cnt++;
      end
      if (o_latch && !latch_q) begin
        check("disp_row", 32'(o_disp_row), 32'(m_row));
        check("disp_bit", 32'(o_disp_bit), 32'(m_bit));
        check("frame_done", 32'(o_frame_done), (m_row == ROWS - 1 && m_bit == BPP - 1) ? 32'd1 : 32'd0);
        check("plane_sclks", 32'(sclk_cnt), 32'(H));
        if (m_bit == BPP - 1) begin
          m_bit = 0;
          m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end else begin
          m_bit = m_bit + 1;
        end
        m_col = 0;
        sclk_cnt = 0;
        latch_cnt++;
      end else if (o_frame_done) begin
        check("frame_done_stray", 32'(o_frame_done), 32'd0);
      end
      if (o_frame_done) fd_cnt++;
      if (o_underrun) und_cnt++;
      sclk_q  = o_sclk;
      latch_q = o_latch;
      if (!en) begin
        m_row = 0; m_bit = 0; m_col = 0; sclk_cnt = 0;
        exp_q.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!o_ready && n < 400) begin step(); n++; end
    ok = o_ready;
    check("ready_wait", 32'(o_ready), 32'd1);
  endtask

  task automatic wait_rd(input int col, output bit ok);
    int n;
    n = 0;
    while (!(o_rd_en && o_rd_col == 6'(col)) && n < 400) begin step(); n++; end
    ok = o_rd_en;
    check("rd_wait", 32'(o_rd_en), 32'd1);
  endtask

  typedef struct packed {
    logic       en;
    logic       lr;
    logic       rd_en;
    logic [5:0] col;
    logic       sclk;
    logic       und;
    logic       rgb0;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit ok;
    int n, planes, fd0, und0, lat0, rd0;

    // en, lr | rd_en, rd_col, sclk, underrun, rgb must be zero
    tbl[0] = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; en = 1'b0; lr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(o_rd_en), 32'd0);
    check("rst_addr", 32'({o_rd_row, o_rd_col}), 32'd0);
    check("rst_rgb", 32'(o_rgb), 32'd0);
    check("rst_strobes", 32'({o_sclk, o_latch, o_ready, o_frame_done, o_underrun}), 32'd0);
    check("rst_disp", 32'({o_disp_row, o_disp_bit}), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; lr = tbl[i].lr;
      step();
      check($sformatf("tbl%0d_rd_en", i), 32'(o_rd_en), 32'(tbl[i].rd_en));
      check($sformatf("tbl%0d_rd_col", i), 32'(o_rd_col), 32'(tbl[i].col));
      check($sformatf("tbl%0d_sclk", i), 32'(o_sclk), 32'(tbl[i].sclk));
      check($sformatf("tbl%0d_underrun", i), 32'(o_underrun), 32'(tbl[i].und));
      check($sformatf("tbl%0d_ready_latch", i), 32'({o_ready, o_latch}), 32'd0);
      if (tbl[i].rgb0) check($sformatf("tbl%0d_rgb", i), 32'(o_rgb), 32'd0);
    end
    lr = 1'b0;

    // First plane: latency from the sampling edge and column count.
    rd0 = rd_cnt;
    en = 1'b1;
    step();
    n = 0;
    while (!o_ready && n < 400) begin step(); n++; end
    check("ready_latency", 32'(n), 32'd193);
    check("reads_per_plane", 32'(rd_cnt - rd0), 32'(H));
    check("sclks_per_plane", 32'(sclk_cnt), 32'(H));

    // Latch the first plane.
    lr = 1'b1;
    step();
    lr = 1'b0;
    check("latch_rise", 32'(o_latch), 32'd1);
    check("latch_disp", 32'({o_disp_row, o_disp_bit}), 32'd0);
    check("latch_ready_low", 32'(o_ready), 32'd0);
    n = 0;
    while (o_latch && n < 20) begin n++; step(); end
    check("latch_width", 32'(n), 32'(LC));
    wait_rd(0, ok);
    check("next_plane_row", 32'(o_rd_row), 32'd0);

    // Rest of the frame, latching whenever the plane is ready.
    planes = 1; fd0 = fd_cnt;
    while (planes < 300) begin
      wait_ready(ok);
      if (!ok) break;
      lr = 1'b1;
      step();
      lr = 1'b0;
      planes++;
      if (o_frame_done) break;
    end
    check("planes_per_frame", 32'(planes), 32'(ROWS * BPP));
    check("final_disp", 32'({o_disp_row, o_disp_bit}), 32'({5'd31, 3'd7}));
    wait_rd(0, ok);
    check("wrap_row", 32'(o_rd_row), 32'd0);
    check("frame_done_once", 32'(fd_cnt - fd0), 32'd1);

    // Latch request during shifting.
    und0 = und_cnt; lat0 = latch_cnt;
    wait_rd(10, ok);
    lr = 1'b1;
    step();
    lr = 1'b0;
    check("midshift_underrun", 32'(o_underrun), 32'd1);
    check("midshift_no_latch", 32'(o_latch), 32'd0);
    step();
    check("midshift_underrun_clear", 32'(o_underrun), 32'd0);
    wait_ready(ok);
    check("midshift_sclks", 32'(sclk_cnt), 32'(H));
    check("midshift_underrun_count", 32'(und_cnt - und0), 32'd1);
    check("midshift_latch_count", 32'(latch_cnt - lat0), 32'd0);

    // Two latches, then disable mid-plane.
    lr = 1'b1; step(); lr = 1'b0;
    wait_ready(ok);
    lr = 1'b1; step(); lr = 1'b0;
    check("pre_disable_disp_bit", 32'(o_disp_bit), 32'd1);
    wait_rd(30, ok);
    en = 1'b0;
    step();
    check("disable_outs", 32'({o_rd_en, o_rd_row, o_rd_col, o_rgb, o_sclk, o_latch, o_ready,
                               o_disp_row, o_disp_bit, o_frame_done, o_underrun}), 32'd0);
    step();
    en = 1'b1;
    wait_rd(0, ok);
    check("reenable_row", 32'(o_rd_row), 32'd0);
    wait_ready(ok);
    check("reenable_sclks", 32'(sclk_cnt), 32'(H));

    // Disable and latch request together while waiting.
    lat0 = latch_cnt; und0 = und_cnt;
    en = 1'b0; lr = 1'b1;
    step();
    lr = 1'b0;
    check("dis_lr_latch", 32'(o_latch), 32'd0);
    check("dis_lr_underrun", 32'(o_underrun), 32'd0);
    check("dis_lr_ready", 32'(o_ready), 32'd0);
    step();
    check("dis_lr_idle_outs", 32'({o_rd_en, o_sclk, o_latch, o_ready, o_underrun, o_frame_done}), 32'd0);
    step();
    check("dis_lr_latch_count", 32'(latch_cnt - lat0), 32'd0);
    check("dis_lr_underrun_count", 32'(und_cnt - und0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Sequences one HUB75 panel: fetches pixel words from the frame buffer, serialises one bit plane of one row into the panel shift chain, then latches it on request from the display timer.
- Sits between the frame-buffer read port and the panel pins.
- Drives the row/bit-plane selection consumed by hub75_timer, and shifts the next plane while the timer displays the current one.

Parameters:
- hpixel_p, 64, columns per row (shift clocks per plane)
- vpixel_p, 64, panel rows in total
- segments_p, 2, rows driven in parallel (one RGB triplet each)
- bpp_p, 8, bits per colour channel (bit planes per row)
- latch_cycles_p, 1, width of o_latch pulse in clocks (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  run; low forces IDLE
- i_latch_req  in  1  one-cycle pulse from timer: blanking window open, latch allowed
- o_rd_en  out  1  frame-buffer read strobe
- o_rd_row  out  $clog2(vpixel_p/segments_p)  read row address
- o_rd_col  out  $clog2(hpixel_p)  read column address
- i_rd_data  in  segments_p*3*bpp_p  read data, valid exactly 1 cycle after o_rd_en; field (s*3+c)*bpp_p +: bpp_p, where c is R=0/G=1/B=2
- o_rgb  out  segments_p*3  panel data; bit s*3+c = selected plane bit of field (s,c)
- o_sclk  out  1  panel shift clock
- o_latch  out  1  panel latch
- o_ready  out  1  plane fully shifted, waiting for i_latch_req
- o_disp_row  out  $clog2(vpixel_p/segments_p)  row now latched (to row select and timer)
- o_disp_bit  out  $clog2(bpp_p)  bit plane now latched (to timer i_pix_bit)
- o_frame_done  out  1  one-cycle pulse when last plane of last row is latched
- o_underrun  out  1  one-cycle pulse when i_latch_req is ignored

Behaviour:
- Reset: every output is 0; the state is IDLE and the internal row/bit/column counters are 0.
- States: IDLE, READ, SETUP, CLK, WAIT_LATCH, LATCH. All outputs are registered.
- IDLE: if i_enable, go to READ with col=0. Otherwise stay.
- READ (1 cycle): o_rd_en=1, o_rd_row=row, o_rd_col=col, o_sclk=0. Go to SETUP.
- SETUP (1 cycle): capture i_rd_data. o_rgb = bit `bit` of each field. o_sclk=0. Go to CLK.
- CLK (1 cycle): o_sclk=1 with o_rgb held.
  - col<hpixel_p-1: col+1, go to READ.
  - Else: go to WAIT_LATCH.
- Shifting costs exactly 3 cycles per column. o_rgb is stable for the whole SETUP..CLK span of a column.
- WAIT_LATCH: o_ready=1, o_sclk=0.
  - On i_latch_req: go to LATCH, o_ready=0. On the same edge, o_latch=1, o_disp_row=row and o_disp_bit=bit.
- LATCH: o_latch held for latch_cycles_p cycles. Then o_latch=0, the counters advance, and the state goes to READ with col=0.
- Counter advance order:
  - bit+1.
  - If bit==bpp_p-1: bit=0 and row+1.
  - If that row was rows-1 (rows = vpixel_p/segments_p): row=0, and o_frame_done pulses on the edge o_latch rises for that final plane.
- Latency: i_enable sampled high at edge E gives o_ready=1 from edge E+1+3*hpixel_p.
- i_latch_req in any state other than WAIT_LATCH (including LATCH) while i_enable=1: ignored, o_underrun pulses the next cycle, and state is unchanged.
- i_latch_req while disabled: ignored, no underrun.
- i_enable low in any state: next edge goes to IDLE.
  - o_sclk, o_latch, o_ready, o_rd_en go to 0.
  - row/bit/col go to 0.
  - o_disp_row/o_disp_bit go to 0.
  - A partially shifted plane is discarded. Re-enable restarts at row 0, bit 0.
- i_enable low and i_latch_req together: disable wins, no latch.
- o_frame_done and o_underrun are never asserted in IDLE.

Test Plan:
- Reset then enable, hpixel_p=64, buffer returns addr-derived data:
  - o_rd_col steps 0..63, 64 o_sclk rising edges.
  - o_ready rises 193 cycles after enable.
  - o_rgb at each rising edge matches bit 0 of each field.
- In WAIT_LATCH pulse i_latch_req:
  - o_latch high for latch_cycles_p cycles.
  - o_disp_row=0, o_disp_bit=0.
  - Next o_rd_en follows with bit=1.
- Run a full frame with bpp_p=8, rows=32, latch_req issued whenever o_ready:
  - bit wraps 7->0 with row+1.
  - o_frame_done pulses exactly once, when (row 31, bit 7) is latched.
  - Counters return to (0,0).
- Pulse i_latch_req mid-shift (col=10):
  - o_underrun pulses once.
  - Shift continues uninterrupted.
  - No o_latch.
- Deassert i_enable at col=30:
  - Next cycle the state is IDLE and all outputs are 0.
  - Re-enable refetches row 0 bit 0 from col 0.
- i_enable low together with i_latch_req in WAIT_LATCH: no o_latch, no o_underrun, IDLE next cycle.
